fft1024_stream_ctrl: RTL and testbench

FFT1024_STREAM_CTRL -- requirements
Module: fft1024_stream_ctrl

---
 rtl/fft1024_stream_ctrl_pkg.sv | 35 +++
 rtl/fft1024_stream_ctrl_bitrev9.sv | 17 +
 rtl/fft1024_stream_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_fft1024_stream_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft1024_stream_ctrl_pkg.sv
// Shared constants, state encodings and bit-reversal helper for the
// 1024-point FFT stream controller.
package fft1024_stream_ctrl_pkg;

   localparam int FFT_N    = 1024;
   localparam int FFT_HALF = FFT_N / 2;
   localparam int CNT_W    = 10;
   localparam int AD_W     = 11;
   localparam int BR_W     = 9;

   typedef enum logic [2:0] {
      S_LOAD   = 3'd0,
      S_DRAIN  = 3'd1,
      S_KICK   = 3'd2,
      S_WAIT   = 3'd3,
      S_UNLOAD = 3'd4
   } state_t;

   // Read pipeline position of the result currently being fetched.
   typedef enum logic [1:0] {
      PH_A = 2'd0,
      PH_B = 2'd1,
      PH_C = 2'd2,
      PH_V = 2'd3
   } rd_phase_t;

   function automatic logic [BR_W-1:0] bitrev9(input logic [BR_W-1:0] v);
      logic [BR_W-1:0] r;
      for (int i = 0; i < BR_W; i++) begin
         r[i] = v[BR_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft1024_stream_ctrl_bitrev9.sv
// 9-bit combinational bit reversal used to scatter load samples into
// the bit-reversed order the FFT engine expects.
module fft_bitrev9
   import fft1024_stream_ctrl_pkg::*;
(
   input  logic [BR_W-1:0] din,
   output logic [BR_W-1:0] dout
);

   genvar gi;
   generate
      for (gi = 0; gi < BR_W; gi++) begin : g_rev
         assign dout[gi] = din[BR_W-1-gi];
      end
   endgenerate

endmodule

// File: rtl/fft1024_stream_ctrl.sv
// Streams a 1024-sample frame into two BSRAMs, hands them to the FFT
// engine, then streams the results back out in natural order.
module fft1024_stream_ctrl
   import fft1024_stream_ctrl_pkg::*;
#(
   parameter int N = FFT_N
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last,
   output logic        fft_start,
   input  logic        fft_finish,
   output logic        fft_clear,
   output logic        sel_fft,
   input  logic [31:0] dout0,
   output logic        oce0,
   output logic        ce0,
   output logic        wre0,
   output logic [10:0] ad0,
   output logic [31:0] din0,
   input  logic [31:0] dout1,
   output logic        oce1,
   output logic        ce1,
   output logic        wre1,
   output logic [10:0] ad1,
   output logic [31:0] din1
);

   localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N - 1);

   state_t            state_reg, state_next;
   rd_phase_t         phase_reg;
   logic [CNT_W-1:0]  n_cnt_reg;
   logic [CNT_W-1:0]  m_cnt_reg;
   logic              m_valid_reg;
   logic              m_last_reg;
   logic [31:0]       m_data_reg;
   logic              clear_reg;

   logic              beat;
   logic              rd_issue;
   logic              rd_oce;
   logic [CNT_W-1:0]  rd_idx;
   logic [BR_W-1:0]   ld_addr9;

   logic [1:0]        wr_wre_reg;
   logic [AD_W-1:0]   wr_ad_reg  [2];
   logic [31:0]       wr_din_reg [2];

   logic [31:0]       dout_arr [2];
   logic [1:0]        ce_arr;
   logic [1:0]        oce_arr;
   logic [AD_W-1:0]   ad_arr [2];

   fft_bitrev9 u_bitrev (
      .din  (n_cnt_reg[CNT_W-1:1]),
      .dout (ld_addr9)
   );

   always_comb begin
      state_next = state_reg;
      s_ready    = 1'b0;
      beat       = 1'b0;
      fft_start  = 1'b0;
      sel_fft    = 1'b0;
      rd_issue   = 1'b0;
      rd_oce     = 1'b0;
      rd_idx     = m_cnt_reg;
      case (state_reg)
         S_LOAD: begin
            s_ready = 1'b1;
            beat    = s_valid;
            if (s_valid && (n_cnt_reg == N_LAST)) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_next = S_KICK;
         end
         S_KICK: begin
            fft_start  = 1'b1;
            sel_fft    = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            sel_fft = 1'b1;
            if (fft_finish) begin
               state_next = S_UNLOAD;
            end
         end
         S_UNLOAD: begin
            rd_oce = 1'b1;
            if (phase_reg == PH_A) begin
               rd_issue = 1'b1;
            end else if ((phase_reg == PH_V) && m_ready) begin
               if (m_last_reg) begin
                  state_next = S_LOAD;
               end else begin
                  // The handshake cycle doubles as the address cycle of the next result.
                  rd_issue = 1'b1;
                  rd_idx   = m_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_LOAD;
         phase_reg   <= PH_A;
         n_cnt_reg   <= '0;
         m_cnt_reg   <= '0;
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
         m_data_reg  <= '0;
         clear_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         clear_reg <= (state_reg == S_WAIT) && fft_finish;
         if (beat) begin
            n_cnt_reg <= n_cnt_reg + 1'b1;
         end
         if (state_reg == S_UNLOAD) begin
            case (phase_reg)
               PH_A: phase_reg <= PH_B;
               PH_B: phase_reg <= PH_C;
               PH_C: begin
                  m_data_reg  <= dout_arr[m_cnt_reg[CNT_W-1]];
                  m_last_reg  <= (m_cnt_reg == N_LAST);
                  m_valid_reg <= 1'b1;
                  phase_reg   <= PH_V;
               end
               PH_V: begin
                  if (m_ready) begin
                     m_valid_reg <= 1'b0;
                     if (m_last_reg) begin
                        m_last_reg <= 1'b0;
                        m_cnt_reg  <= '0;
                        n_cnt_reg  <= '0;
                        phase_reg  <= PH_A;
                     end else begin
                        m_cnt_reg <= m_cnt_reg + 1'b1;
                        phase_reg <= PH_B;
                     end
                  end
               end
               default: phase_reg <= PH_A;
            endcase
         end
      end
   end

   assign dout_arr[0] = dout0;
   assign dout_arr[1] = dout1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         logic rd_ce;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_wre_reg[gi] <= 1'b0;
               wr_ad_reg[gi]  <= '0;
               wr_din_reg[gi] <= '0;
            end else if (beat && (n_cnt_reg[0] == 1'(gi))) begin
               wr_wre_reg[gi] <= 1'b1;
               wr_ad_reg[gi]  <= {2'b00, ld_addr9};
               wr_din_reg[gi] <= s_data;
            end else begin
               wr_wre_reg[gi] <= 1'b0;
               wr_ad_reg[gi]  <= '0;
               wr_din_reg[gi] <= '0;
            end
         end

         assign rd_ce       = rd_issue && (rd_idx[CNT_W-1] == 1'(gi));
         assign ce_arr[gi]  = wr_wre_reg[gi] | rd_ce;
         assign oce_arr[gi] = rd_oce;
         assign ad_arr[gi]  = wr_wre_reg[gi] ? wr_ad_reg[gi] :
                              rd_ce          ? {2'b00, rd_idx[BR_W-1:0]} : '0;
      end
   endgenerate

   assign ce0  = ce_arr[0];
   assign oce0 = oce_arr[0];
   assign wre0 = wr_wre_reg[0];
   assign ad0  = ad_arr[0];
   assign din0 = wr_din_reg[0];
   assign ce1  = ce_arr[1];
   assign oce1 = oce_arr[1];
   assign wre1 = wr_wre_reg[1];
   assign ad1  = ad_arr[1];
   assign din1 = wr_din_reg[1];

   assign m_valid   = m_valid_reg;
   assign m_last    = m_last_reg;
   assign m_data    = m_data_reg;
   assign fft_clear = clear_reg;

endmodule

// File: tb/tb_fft1024_stream_ctrl.sv
// Scoreboard bench: load writes and unload results are predicted from the
// frame rules, BSRAMs and the FFT engine are behavioural stubs.
`timescale 1ns/1ps
module tb_fft1024_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic        m_last;
   logic        fft_start;
   logic        fft_finish = 1'b0;
   logic        fft_clear;
   logic        sel_fft;
   logic [31:0] dout0, dout1;
   logic        oce0, ce0, wre0, oce1, ce1, wre1;
   logic [10:0] ad0, ad1;
   logic [31:0] din0, din1;

   fft1024_stream_ctrl #(.N(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .fft_start(fft_start), .fft_finish(fft_finish), .fft_clear(fft_clear), .sel_fft(sel_fft),
      .dout0(dout0), .oce0(oce0), .ce0(ce0), .wre0(wre0), .ad0(ad0), .din0(din0),
      .dout1(dout1), .oce1(oce1), .ce1(ce1), .wre1(wre1), .ad1(ad1), .din1(din1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int brev9(input int v);
      int r = 0;
      for (int i = 0; i < 9; i++) if (((v >> i) & 1) != 0) r |= (1 << (8 - i));
      return r;
   endfunction

   // Contents the FFT stub leaves in bank k at address a for a given frame.
   function automatic logic [31:0] pattern(input int f, input int k, input int a);
      return {8'(f + 8'h5a), 3'b101, 1'(k), 9'h0, 11'(a)};
   endfunction

   typedef struct { int n; int k; int addr; logic [31:0] data; } wr_t;
   typedef struct { int m; logic [31:0] data; logic last; } res_t;
   wr_t  wr_q[$];
   res_t res_q[$];

   // Frame parameters owned by the main process.
   int frame_id  = 0;
   int fin_delay = 50;
   bit ready_all = 1'b1;

   // BSRAM models: address sampled at the end of cycle t, data out during t+2.
   logic [31:0] mem [2][2048];
   logic [31:0] st1 [2];
   logic [31:0] dq  [2];
   int fill_seq  = 0;
   int fill_done = 0;
   wire [1:0]   ce_w  = {ce1, ce0};
   wire [1:0]   oce_w = {oce1, oce0};
   wire [1:0]   wre_w = {wre1, wre0};
   logic [10:0] ad_w  [2];
   logic [31:0] din_w [2];
   assign ad_w[0] = ad0;   assign ad_w[1] = ad1;
   assign din_w[0] = din0; assign din_w[1] = din1;
   assign dout0 = dq[0];
   assign dout1 = dq[1];

   always @(posedge clk) begin
      if (fill_seq != fill_done) begin
         for (int k = 0; k < 2; k++)
            for (int a = 0; a < 512; a++) mem[k][a] <= pattern(frame_id, k, a);
         fill_done <= fill_seq;
      end
      for (int k = 0; k < 2; k++) begin
         if (oce_w[k]) dq[k] <= st1[k];
         if (ce_w[k] && wre_w[k]) mem[k][ad_w[k]] <= din_w[k];
         else if (ce_w[k]) st1[k] <= mem[k][ad_w[k]];
      end
   end

   always @(posedge clk) begin
      #1;
      m_ready = ready_all ? 1'b1 : ($urandom_range(0, 99) >= 30);
   end

   // Monitor and FFT stub.
   int beat_cnt = 0, c_last = -100, cs = -100, fin_at = -1, clr_exp = -1;
   int res_cnt = 0, last_hs = 0, starts = 0, clears = 0, frame_done_cnt = 0;
   bit stall_prev = 1'b0;
   logic [31:0] hold_data;
   logic hold_last;

   always @(negedge clk) begin
      wr_t  we;
      res_t re;
      if (!rst_n) begin
         beat_cnt = 0; res_cnt = 0; stall_prev = 1'b0; fft_finish = 1'b0;
         fin_at = -1; clr_exp = -1; starts = 0; clears = 0; cs = -100;
      end else begin
         if (s_valid && s_ready) begin
            if (beat_cnt == 1023) c_last = cyc;
            beat_cnt = (beat_cnt + 1) % 1024;
         end
         if (wre0 && wre1) check("dual_write", 64'({wre1, wre0}), 64'b01);
         for (int k = 0; k < 2; k++) begin
            if (wre_w[k]) begin
               check("write_expected", 64'(wr_q.size() > 0), 64'd1);
               if (wr_q.size() > 0) begin
                  we = wr_q.pop_front();
                  check("wr_bank", 64'(k), 64'(we.k));
                  check("wr_addr", 64'(ad_w[k]), 64'(we.addr));
                  check("wr_data", 64'(din_w[k]), 64'(we.data));
                  check("wr_ce", 64'(ce_w[k]), 64'd1);
                  if (we.n == 1023) begin
                     check("last_wr_cycle", 64'(cyc), 64'(c_last + 1));
                     check("last_wr_s_ready", 64'(s_ready), 64'd0);
                  end
               end
            end
         end
         if (sel_fft) check("no_contention", 64'({ce0, ce1, oce0, oce1, wre0, wre1}), 64'd0);
         if (fft_start) begin
            starts++;
            check("start_cycle", 64'(cyc), 64'(c_last + 2));
            check("start_sel", 64'(sel_fft), 64'd1);
            cs      = cyc;
            fin_at  = cs + fin_delay;
            clr_exp = cs + ((fin_delay < 1) ? 1 : fin_delay) + 1;
            fill_seq++;
         end else if (clr_exp >= 0 && cyc > cs && cyc < clr_exp) begin
            check("sel_hold", 64'(sel_fft), 64'd1);
         end
         if (fin_at >= 0 && cyc == fin_at) fft_finish = 1'b1;
         if (fft_clear) begin
            clears++;
            check("clear_cycle", 64'(cyc), 64'(clr_exp));
            check("clear_sel", 64'(sel_fft), 64'd0);
            fft_finish = 1'b0;
            fin_at = -1;
            clr_exp = -1;
         end
         if (stall_prev) begin
            check("stall_valid", 64'(m_valid), 64'd1);
            check("stall_data", 64'(m_data), 64'(hold_data));
            check("stall_last", 64'(m_last), 64'(hold_last));
         end
         if (m_valid && m_ready) begin
            check("result_expected", 64'(res_q.size() > 0), 64'd1);
            if (res_q.size() > 0) begin
               re = res_q.pop_front();
               check("res_data", 64'(m_data), 64'(re.data));
               check("res_last", 64'(m_last), 64'(re.last));
            end
            if (ready_all && res_cnt > 0) check("res_spacing", 64'(cyc - last_hs), 64'd3);
            last_hs = cyc;
            res_cnt++;
            if (m_last) begin
               check("starts_per_frame", 64'(starts), 64'd1);
               check("clears_per_frame", 64'(clears), 64'd1);
               starts = 0; clears = 0; res_cnt = 0;
               frame_done_cnt++;
            end
         end
         stall_prev = m_valid && !m_ready;
         hold_data  = m_data;
         hold_last  = m_last;
      end
   end

   task automatic run_load();
      int n = 0;
      while (n < 1024) begin
         if ($urandom_range(0, 99) < 75) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            check("s_ready_load", 64'(s_ready), 64'd1);
            wr_q.push_back('{n: n, k: n % 2, addr: brev9(n / 2), data: s_data});
            n++;
         end else begin
            s_valid = 1'b0;
            s_data  = $urandom;
         end
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      for (int m = 0; m < 1024; m++)
         res_q.push_back('{m: m, data: pattern(frame_id, m / 512, m % 512), last: (m == 1023)});
   endtask

   task automatic wait_frame(input bit hold);
      int target = frame_done_cnt + 1;
      int t = 0;
      while (frame_done_cnt < target && t < 20000) begin
         if (hold) begin s_valid = 1'b1; s_data = $urandom; end
         @(posedge clk); #1;
         t++;
         if (hold && frame_done_cnt < target) check("s_ready_busy", 64'(s_ready), 64'd0);
      end
      s_valid = 1'b0;
      check("frame_done", 64'(frame_done_cnt >= target), 64'd1);
      check("wr_q_empty", 64'(wr_q.size()), 64'd0);
      check("res_q_empty", 64'(res_q.size()), 64'd0);
      $display("frame %0d done at cycle %0d, errors so far %0d", frame_id, cyc, errors);
   endtask

   task automatic check_reset_outputs();
      check("rst_stream", 64'({m_valid, m_last, fft_start, fft_clear, sel_fft}), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_bsram_ctl", 64'({ce0, oce0, wre0, ce1, oce1, wre1}), 64'd0);
      check("rst_ad", 64'({ad0, ad1}), 64'd0);
      check("rst_din", 64'({din0, din1}), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd1);
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      @(posedge clk); #1;

      frame_id = 0; ready_all = 1'b1; fin_delay = 50;
      run_load();
      wait_frame(1'b0);

      frame_id = 1; ready_all = 1'b0; fin_delay = 0;
      run_load();
      wait_frame(1'b1);

      frame_id = 2; ready_all = 1'b1; fin_delay = 50;
      run_load();
      t = 0;
      while (res_cnt < 300 && t < 20000) begin
         @(posedge clk); #1;
         t++;
      end
      check("reset_point", 64'(res_cnt), 64'd300);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      wr_q.delete();
      res_q.delete();
      repeat (2) @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #3;
      rst_n = 1'b1;
      $display("reset applied during unload, released at cycle %0d", cyc);
      @(posedge clk); #1;

      frame_id = 3; ready_all = 1'b1; fin_delay = 1;
      run_load();
      wait_frame(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
